// File: rtl/pll_cfg_master_if.sv
// Host request/response and PLL dynamic-configuration bus signals for pll_cfg_master.
// master = the configuration initiator; slave = host + PLL side.
interface pll_cfg_master_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_apply;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              locked;
  logic              pllstb;
  logic              pllwe;
  logic [ADDR_W-1:0] plladdr;
  logic [DATA_W-1:0] plldati;
  logic [DATA_W-1:0] plldato;
  logic              pllack;
  logic              pllrst;
  logic              lock;

  modport master (
    input  req, req_we, req_addr, req_wdata, req_apply, plldato, pllack, lock,
    output busy, done, err, rdata, locked, pllstb, pllwe, plladdr, plldati, pllrst
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, req_apply, plldato, pllack, lock,
    input  busy, done, err, rdata, locked, pllstb, pllwe, plladdr, plldati, pllrst
  );
endinterface

// File: rtl/pll_cfg_master.sv
// PLL dynamic-configuration bus initiator: host register read/write plus PLL reset/relock sequencing.
// Optional feature macro: PLL_CFG_ACK_TIMEOUT_EN (abort a bus transfer that sees no PLLACK).
module pll_cfg_master #(
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pll_cfg_master_if.master      cfg_if
);

  // One counter serves reset hold, lock timeout and ack timeout, so size it for the largest limit.
  localparam int unsigned LIM_A   = (LOCK_TIMEOUT > ACK_TIMEOUT) ? LOCK_TIMEOUT : ACK_TIMEOUT;
  localparam int unsigned CNT_LIM = (LIM_A > RST_CYCLES) ? LIM_A : RST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_LIM + 1);
  localparam int unsigned STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_XFER      = 2'd1;
  localparam logic [1:0] S_RST_HOLD  = 2'd2;
  localparam logic [1:0] S_LOCK_WAIT = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dati_q, dati_d;
  logic              pllrst_q, pllrst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              lock_meta_q, locked_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [STAB_W-1:0] stab_inc;

  // Saturating increments
  assign cnt_inc  = (&cnt_q)  ? cnt_q  : cnt_q  + CNT_W'(1);
  assign stab_inc = (&stab_q) ? stab_q : stab_q + STAB_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dati_q      <= '0;
      pllrst_q    <= 1'b0;
      cnt_q       <= '0;
      stab_q      <= '0;
      lock_meta_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      dati_q      <= dati_d;
      pllrst_q    <= pllrst_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      lock_meta_q <= cfg_if.lock;
      locked_q    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    stb_d    = stb_q;
    we_d     = we_q;
    addr_d   = addr_q;
    dati_d   = dati_q;
    pllrst_d = pllrst_q;
    cnt_d    = cnt_q;
    stab_d   = stab_q;

    case (state_q)
      S_IDLE: begin
        // A register request wins over an apply request on the same cycle.
        if (cfg_if.req) begin
          stb_d   = 1'b1;
          we_d    = cfg_if.req_we;
          addr_d  = cfg_if.req_addr;
          dati_d  = cfg_if.req_wdata;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_XFER;
        end else if (cfg_if.req_apply) begin
          pllrst_d = 1'b1;
          busy_d   = 1'b1;
          err_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_RST_HOLD;
        end
      end

      S_XFER: begin
        cnt_d = cnt_inc;
        if (cfg_if.pllack) begin
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (!we_q) rdata_d = cfg_if.plldato;
        end
`ifdef PLL_CFG_ACK_TIMEOUT_EN
        else if (cnt_inc >= CNT_W'(ACK_TIMEOUT)) begin
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end

      S_RST_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          pllrst_d = 1'b0;
          cnt_d    = '0;
          stab_d   = '0;
          state_d  = S_LOCK_WAIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_LOCK_WAIT: begin
        // Stable-lock success takes priority over a simultaneous timeout.
        cnt_d  = cnt_inc;
        stab_d = locked_q ? stab_inc : '0;
        if (locked_q && (stab_inc >= STAB_W'(LOCK_STABLE))) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_inc >= CNT_W'(LOCK_TIMEOUT)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_if.busy    = busy_q;
  assign cfg_if.done    = done_q;
  assign cfg_if.err     = err_q;
  assign cfg_if.rdata   = rdata_q;
  assign cfg_if.locked  = locked_q;
  assign cfg_if.pllstb  = stb_q;
  assign cfg_if.pllwe   = we_q;
  assign cfg_if.plladdr = addr_q;
  assign cfg_if.plldati = dati_q;
  assign cfg_if.pllrst  = pllrst_q;

endmodule

// File: tb/tb_pll_cfg_master.sv
// Bench for pll_cfg_master: transaction-level reference model checked every cycle plus directed literal checks.
module tb_pll_cfg_master;
  localparam int unsigned RST_C = 8;
  localparam int unsigned LSTAB = 16;
  localparam int unsigned LTMO  = 65535;
  localparam int unsigned ATMO  = 255;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pll_cfg_master_if bus();

  pll_cfg_master #(
    .RST_CYCLES  (RST_C),
    .LOCK_STABLE (LSTAB),
    .LOCK_TIMEOUT(LTMO),
    .ACK_TIMEOUT (ATMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .cfg_if(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (expected outputs after each edge) ----------------
  logic       m_busy = 0, m_done = 0, m_err = 0, m_stb = 0, m_we = 0, m_rst = 0;
  logic [4:0] m_addr = 0;
  logic [7:0] m_dati = 0, m_rdata = 0;
  logic       m_lk1 = 0, m_lk2 = 0, l_seen = 0;

  always @(negedge rst_n) begin
    m_busy = 0; m_done = 0; m_err = 0; m_stb = 0; m_we = 0; m_rst = 0;
    m_addr = 0; m_dati = 0; m_rdata = 0; m_lk1 = 0; m_lk2 = 0; l_seen = 0;
  end

  // Advance one clock edge; ab=1 when the edge happened under reset.
  task automatic tick(output bit ab);
    @(posedge clk);
    ab = !rst_n;
    if (!ab) begin
      l_seen = m_lk2;
      m_lk2  = m_lk1;
      m_lk1  = bus.lock;
      m_done = 0;
    end
  endtask

  always begin : p_model
    bit ab;
    int unsigned n, st, t;
    tick(ab);
    if (!ab && bus.req) begin
      m_busy = 1; m_err = 0; m_stb = 1;
      m_we = bus.req_we; m_addr = bus.req_addr; m_dati = bus.req_wdata;
      n = 0;
      forever begin
        tick(ab);
        if (ab) break;
        n++;
        if (bus.pllack) begin
          m_stb = 0; m_busy = 0; m_done = 1;
          if (!m_we) m_rdata = bus.plldato;
          break;
        end
`ifdef PLL_CFG_ACK_TIMEOUT_EN
        if (n >= ATMO) begin
          m_stb = 0; m_busy = 0; m_done = 1; m_err = 1;
          break;
        end
`endif
      end
    end else if (!ab && bus.req_apply) begin
      m_busy = 1; m_err = 0; m_rst = 1;
      for (int k = 0; k < int'(RST_C); k++) begin
        tick(ab);
        if (ab) break;
      end
      if (!ab) begin
        m_rst = 0; st = 0; t = 0;
        forever begin
          tick(ab);
          if (ab) break;
          t++;
          st = l_seen ? st + 1 : 0;
          if (st >= LSTAB) begin m_busy = 0; m_done = 1; m_err = 0; break; end
          if (t >= LTMO)   begin m_busy = 0; m_done = 1; m_err = 1; break; end
        end
      end
    end
  end

  // Per-cycle comparison and event counters
  int cyc = 0, stb_hi = 0, rst_hi = 0, done_n = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.pllstb) stb_hi++;
    if (bus.pllrst) rst_hi++;
    if (bus.done) begin done_n++; done_cyc = cyc; end
    chk("busy",    32'(bus.busy),    32'(m_busy));
    chk("done",    32'(bus.done),    32'(m_done));
    chk("err",     32'(bus.err),     32'(m_err));
    chk("rdata",   32'(bus.rdata),   32'(m_rdata));
    chk("locked",  32'(bus.locked),  32'(m_lk2));
    chk("pllstb",  32'(bus.pllstb),  32'(m_stb));
    chk("pllwe",   32'(bus.pllwe),   32'(m_we));
    chk("plladdr", 32'(bus.plladdr), 32'(m_addr));
    chk("plldati", 32'(bus.plldati), 32'(m_dati));
    chk("pllrst",  32'(bus.pllrst),  32'(m_rst));
  end

  // ---------------- directed stimulus ----------------
  int   c0, ce;
  logic s_we, s_err;
  logic [4:0] s_addr;
  logic [7:0] s_dati;

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait budget expired (t=%0t)", nm, $time);
  endtask

  // Register transfer; PLLACK is sampled on the dly-th edge after the accept edge.
  task automatic xfer(input logic we, input logic [4:0] a, input logic [7:0] wd,
                      input int dly, input logic [7:0] dato);
    nstep();
    bus.req = 1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    stb_hi = 0; done_n = 0; c0 = cyc + 1;
    nstep();
    bus.req = 0;
    s_we = bus.pllwe; s_addr = bus.plladdr; s_dati = bus.plldati; s_err = bus.err;
    repeat (dly - 1) nstep();
    bus.pllack = 1; bus.plldato = dato;
    nstep();
    bus.pllack = 0;
    nstep();
  endtask

  // Apply sequence; rise<0 keeps LOCK low, glitch>0 drops LOCK for one cycle at that offset.
  task automatic apply_seq(input int rise, input int glitch, input int budget);
    int b;
    nstep();
    bus.req_apply = 1; rst_hi = 0; done_n = 0;
    nstep();
    bus.req_apply = 0;
    b = 0;
    while (bus.pllrst && b < 100) begin nstep(); b++; end
    if (b >= 100) timeout_fail("pllrst_release");
    ce = cyc;
    chk("pllrst_hold_cycles", 32'(rst_hi), 32'(RST_C));
    if (rise >= 0) begin
      repeat (rise) nstep();
      bus.lock = 1;
      if (glitch > 0) begin
        repeat (glitch - rise) nstep();
        bus.lock = 0;
        nstep();
        bus.lock = 1;
      end
    end
    b = 0;
    while (done_n == 0 && b < budget) begin nstep(); b++; end
    if (b >= budget) timeout_fail("apply_done");
  endtask

  initial begin
    bus.req = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_apply = 0;
    bus.plldato = 0; bus.pllack = 0; bus.lock = 1;

    // Reset state, with LOCK high to show the synchroniser stays cleared
    repeat (3) nstep();
    chk("rst_busy",   32'(bus.busy),   0);
    chk("rst_pllstb", 32'(bus.pllstb), 0);
    chk("rst_pllrst", 32'(bus.pllrst), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_rdata",  32'(bus.rdata),  0);
    bus.lock = 0;
    rst_n = 1;
    repeat (3) nstep();

    // LOCKED follows LOCK two edges later
    bus.lock = 1;
    nstep();
    chk("locked_lat1", 32'(bus.locked), 0);
    nstep();
    chk("locked_lat2", 32'(bus.locked), 1);
    bus.lock = 0;
    repeat (3) nstep();

    // 1: write 0x05 <= 0xA3, ACK after 3 cycles
    xfer(1'b1, 5'h05, 8'hA3, 3, 8'h00);
    chk("t1_pllwe",   32'(s_we),   1);
    chk("t1_plladdr", 32'(s_addr), 32'h05);
    chk("t1_plldati", 32'(s_dati), 32'hA3);
    chk("t1_stb_cycles", 32'(stb_hi), 3);
    chk("t1_done_count", 32'(done_n), 1);
    chk("t1_done_lat",   32'(done_cyc - c0), 3);
    chk("t1_err", 32'(bus.err), 0);

    // 2: read 0x1F with ACK after 1 cycle, then a write must keep RDATA
    xfer(1'b0, 5'h1F, 8'h00, 1, 8'h5C);
    chk("t2_done_lat", 32'(done_cyc - c0), 1);
    chk("t2_rdata", 32'(bus.rdata), 32'h5C);
    xfer(1'b1, 5'h03, 8'h77, 2, 8'hEE);
    chk("t2_rdata_after_wr", 32'(bus.rdata), 32'h5C);

    // PLLACK while idle is ignored
    done_n = 0;
    bus.pllack = 1; bus.plldato = 8'h11;
    repeat (2) nstep();
    bus.pllack = 0;
    nstep();
    chk("idle_ack_done", 32'(done_n), 0);
    chk("idle_ack_rdata", 32'(bus.rdata), 32'h5C);

    // 3: apply, LOCK rises 20 cycles after PLLRST falls
    apply_seq(20, 0, 200);
    chk("t3_done_lat", 32'(done_cyc - ce), 38);
    chk("t3_err", 32'(bus.err), 0);
    bus.lock = 0;
    repeat (4) nstep();

    // 4: LOCK glitch after 10 stable counts restarts the count
    apply_seq(20, 32, 200);
    chk("t4_done_lat", 32'(done_cyc - ce), 51);
    chk("t4_err", 32'(bus.err), 0);
    bus.lock = 0;
    repeat (4) nstep();

    // 5: LOCK stuck low -> lock timeout; next accept clears ERR
    apply_seq(-1, 0, 70000);
    chk("t5_done_lat", 32'(done_cyc - ce), LTMO);
    chk("t5_err", 32'(bus.err), 1);
    xfer(1'b1, 5'h0A, 8'h3C, 1, 8'h00);
    chk("t5_err_cleared", 32'(s_err), 0);

`ifdef PLL_CFG_ACK_TIMEOUT_EN
    begin : t5_ack_timeout
      int b;
      nstep();
      bus.req = 1; bus.req_we = 0; bus.req_addr = 5'h07; done_n = 0; c0 = cyc + 1;
      nstep();
      bus.req = 0;
      b = 0;
      while (done_n == 0 && b < 400) begin nstep(); b++; end
      if (b >= 400) timeout_fail("ack_timeout_done");
      chk("t5_ack_tmo_lat", 32'(done_cyc - c0), ATMO);
      chk("t5_ack_tmo_err", 32'(bus.err), 1);
      chk("t5_ack_tmo_rdata", 32'(bus.rdata), 32'h5C);
    end
`endif

    // 6a: reset during XFER
    nstep();
    bus.req = 1; bus.req_we = 1; bus.req_addr = 5'h02; bus.req_wdata = 8'h99; done_n = 0;
    nstep();
    bus.req = 0;
    nstep();
    chk("t6_stb_before", 32'(bus.pllstb), 1);
    #2 rst_n = 0;
    #1 chk("t6_stb_async", 32'(bus.pllstb), 0);
    chk("t6_busy_async", 32'(bus.busy), 0);
    repeat (2) nstep();
    rst_n = 1;
    repeat (5) nstep();
    chk("t6_no_done_xfer", 32'(done_n), 0);

    // 6b: reset during RST_HOLD
    nstep();
    bus.req_apply = 1;
    nstep();
    bus.req_apply = 0;
    repeat (2) nstep();
    chk("t6_rst_before", 32'(bus.pllrst), 1);
    #2 rst_n = 0;
    #1 chk("t6_rst_async", 32'(bus.pllrst), 0);
    repeat (2) nstep();
    rst_n = 1;
    repeat (12) nstep();
    chk("t6_no_done_apply", 32'(done_n), 0);

    // 6c: REQ and REQ_APPLY together -> only the register read runs
    nstep();
    bus.req = 1; bus.req_apply = 1; bus.req_we = 0; bus.req_addr = 5'h02;
    rst_hi = 0; done_n = 0;
    nstep();
    bus.req = 0; bus.req_apply = 0;
    bus.pllack = 1; bus.plldato = 8'h42;
    nstep();
    bus.pllack = 0;
    repeat (12) nstep();
    chk("t6_both_no_rst", 32'(rst_hi), 0);
    chk("t6_both_done",   32'(done_n), 1);
    chk("t6_both_rdata",  32'(bus.rdata), 32'h42);
    chk("t6_both_idle",   32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
